// File: rtl/mips_ctrl_pkg.sv
// Shared types and constants for the multicycle MIPS control path.
// aludec pulls its ALUOP_* encodings from here as well.
package mips_ctrl_pkg;

    localparam int OPW    = 6;
    localparam int ALUOPW = 3;

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXECUTE = 4'd6,
        S_ALUWB   = 4'd7,
        S_BEQ     = 4'd8,
        S_BLT     = 4'd9,
        S_ADDIEX  = 4'd10,
        S_LIEX    = 4'd11,
        S_ADDIWB  = 4'd12,
        S_JUMP    = 4'd13
    } statetype;

    localparam logic [OPW-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OPW-1:0] OP_LW    = 6'b100011;
    localparam logic [OPW-1:0] OP_SW    = 6'b101011;
    localparam logic [OPW-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OPW-1:0] OP_BLT   = 6'b000110;
    localparam logic [OPW-1:0] OP_ADDI  = 6'b001000;
    localparam logic [OPW-1:0] OP_LI    = 6'b001111;
    localparam logic [OPW-1:0] OP_J     = 6'b000010;

    localparam logic [ALUOPW-1:0] ALUOP_ADD   = 3'b000;
    localparam logic [ALUOPW-1:0] ALUOP_SUB   = 3'b001;
    localparam logic [ALUOPW-1:0] ALUOP_FUNCT = 3'b010;
    localparam logic [ALUOPW-1:0] ALUOP_SLT   = 3'b011;
    localparam logic [ALUOPW-1:0] ALUOP_LI    = 3'b100;

endpackage

// File: rtl/multicycle_ctrl.sv
// Main control FSM of the multicycle MIPS core: sequences fetch, decode,
// execute, memory and writeback steps, stalling on memory until mem_ready.
module multicycle_ctrl
    import mips_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic [OPW-1:0]    op,
    input  logic              mem_ready,
    output logic              irwrite,
    output logic              pcwrite,
    output logic              branch,
    output logic              bltbranch,
    output logic              iord,
    output logic              memwrite,
    output logic              memtoreg,
    output logic              regdst,
    output logic              regwrite,
    output logic              alusrca,
    output logic [1:0]        alusrcb,
    output logic [1:0]        pcsrc,
    output logic [ALUOPW-1:0] aluop,
    output logic              illegal_op,
    output statetype          dbg_state
);

    statetype state_q;
    statetype state_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    assign dbg_state = state_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:   if (mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_EXECUTE;
                    OP_BEQ:       state_d = S_BEQ;
                    OP_BLT:       state_d = S_BLT;
                    OP_ADDI:      state_d = S_ADDIEX;
                    OP_LI:        state_d = S_LIEX;
                    OP_J:         state_d = S_JUMP;
                    default:      state_d = S_FETCH;
                endcase
            end
            S_MEMADR:  state_d = (op == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:   if (mem_ready) state_d = S_MEMWB;
            S_MEMWR:   if (mem_ready) state_d = S_FETCH;
            S_EXECUTE: state_d = S_ALUWB;
            S_ADDIEX:  state_d = S_ADDIWB;
            S_LIEX:    state_d = S_ADDIWB;
            S_MEMWB, S_ALUWB, S_BEQ, S_BLT, S_ADDIWB, S_JUMP:
                       state_d = S_FETCH;
            default:   state_d = S_FETCH;
        endcase
    end

    // Outputs follow the state register; the only input-qualified strobes are
    // the FETCH completion (mem_ready) and the DECODE illegal-opcode flag.
    always_comb begin
        irwrite    = 1'b0;
        pcwrite    = 1'b0;
        branch     = 1'b0;
        bltbranch  = 1'b0;
        iord       = 1'b0;
        memwrite   = 1'b0;
        memtoreg   = 1'b0;
        regdst     = 1'b0;
        regwrite   = 1'b0;
        alusrca    = 1'b0;
        alusrcb    = 2'b00;
        pcsrc      = 2'b00;
        aluop      = ALUOP_ADD;
        illegal_op = 1'b0;
        case (state_q)
            S_FETCH: begin
                alusrcb = 2'b01;
                // Held low during reset so a ready memory cannot load IR/PC.
                irwrite = mem_ready & reset_n;
                pcwrite = mem_ready & reset_n;
            end
            S_DECODE: begin
                alusrcb = 2'b11;
                case (op)
                    OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_BLT,
                    OP_ADDI, OP_LI, OP_J: illegal_op = 1'b0;
                    default:              illegal_op = 1'b1;
                endcase
            end
            S_MEMADR: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
            end
            S_MEMRD: iord = 1'b1;
            S_MEMWB: begin
                memtoreg = 1'b1;
                regwrite = 1'b1;
            end
            S_MEMWR: begin
                iord     = 1'b1;
                memwrite = 1'b1;
            end
            S_EXECUTE: begin
                alusrca = 1'b1;
                aluop   = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                regdst   = 1'b1;
                regwrite = 1'b1;
            end
            S_BEQ: begin
                alusrca = 1'b1;
                aluop   = ALUOP_SUB;
                pcsrc   = 2'b01;
                branch  = 1'b1;
            end
            S_BLT: begin
                alusrca   = 1'b1;
                aluop     = ALUOP_SLT;
                pcsrc     = 2'b01;
                bltbranch = 1'b1;
            end
            S_ADDIEX: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
            end
            S_LIEX: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                aluop   = ALUOP_LI;
            end
            S_ADDIWB: regwrite = 1'b1;
            S_JUMP: begin
                pcsrc   = 2'b10;
                pcwrite = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: a per-cycle vector table for the
// normal instruction flows, plus sequences for stalls, illegal op and reset.
module tb_multicycle_ctrl;
    import mips_ctrl_pkg::*;

    logic              clk;
    logic              reset_n;
    logic [OPW-1:0]    op;
    logic              mem_ready;
    logic              irwrite, pcwrite, branch, bltbranch, iord, memwrite;
    logic              memtoreg, regdst, regwrite, alusrca, illegal_op;
    logic [1:0]        alusrcb, pcsrc;
    logic [ALUOPW-1:0] aluop;
    statetype          dbg_state;

    int total = 0;
    int bad   = 0;

    multicycle_ctrl dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .op         (op),
        .mem_ready  (mem_ready),
        .irwrite    (irwrite),
        .pcwrite    (pcwrite),
        .branch     (branch),
        .bltbranch  (bltbranch),
        .iord       (iord),
        .memwrite   (memwrite),
        .memtoreg   (memtoreg),
        .regdst     (regdst),
        .regwrite   (regwrite),
        .alusrca    (alusrca),
        .alusrcb    (alusrcb),
        .pcsrc      (pcsrc),
        .aluop      (aluop),
        .illegal_op (illegal_op),
        .dbg_state  (dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {irwrite,pcwrite,branch,bltbranch,iord,memwrite,memtoreg,regdst,regwrite,
    //  alusrca,alusrcb[1:0],pcsrc[1:0],aluop[2:0],illegal_op}
    function automatic logic [17:0] mk(
        input logic irw, input logic pcw, input logic br, input logic blt,
        input logic io, input logic mw, input logic m2r, input logic rd,
        input logic rw, input logic asa, input logic [1:0] asb,
        input logic [1:0] pcs, input logic [2:0] aop, input logic ill);
        return {irw, pcw, br, blt, io, mw, m2r, rd, rw, asa, asb, pcs, aop, ill};
    endfunction

    logic [17:0] c_fwait, c_frdy, c_dec, c_decill, c_memadr, c_memrd, c_memwb;
    logic [17:0] c_memwr, c_exec, c_aluwb, c_beq, c_blt, c_addiex, c_liex;
    logic [17:0] c_addiwb, c_jump;

    initial begin
        c_fwait  = mk(0,0,0,0,0,0,0,0,0,0,2'b01,2'b00,3'b000,0);
        c_frdy   = mk(1,1,0,0,0,0,0,0,0,0,2'b01,2'b00,3'b000,0);
        c_dec    = mk(0,0,0,0,0,0,0,0,0,0,2'b11,2'b00,3'b000,0);
        c_decill = mk(0,0,0,0,0,0,0,0,0,0,2'b11,2'b00,3'b000,1);
        c_memadr = mk(0,0,0,0,0,0,0,0,0,1,2'b10,2'b00,3'b000,0);
        c_memrd  = mk(0,0,0,0,1,0,0,0,0,0,2'b00,2'b00,3'b000,0);
        c_memwb  = mk(0,0,0,0,0,0,1,0,1,0,2'b00,2'b00,3'b000,0);
        c_memwr  = mk(0,0,0,0,1,1,0,0,0,0,2'b00,2'b00,3'b000,0);
        c_exec   = mk(0,0,0,0,0,0,0,0,0,1,2'b00,2'b00,3'b010,0);
        c_aluwb  = mk(0,0,0,0,0,0,0,1,1,0,2'b00,2'b00,3'b000,0);
        c_beq    = mk(0,0,1,0,0,0,0,0,0,1,2'b00,2'b01,3'b001,0);
        c_blt    = mk(0,0,0,1,0,0,0,0,0,1,2'b00,2'b01,3'b011,0);
        c_addiex = mk(0,0,0,0,0,0,0,0,0,1,2'b10,2'b00,3'b000,0);
        c_liex   = mk(0,0,0,0,0,0,0,0,0,1,2'b10,2'b00,3'b100,0);
        c_addiwb = mk(0,0,0,0,0,0,0,0,1,0,2'b00,2'b00,3'b000,0);
        c_jump   = mk(0,1,0,0,0,0,0,0,0,0,2'b00,2'b10,3'b000,0);
    end

    typedef struct {
        logic        mr;
        logic [5:0]  opc;
        statetype    st;
        logic [17:0] ctl;
        string       nm;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic mr, input logic [5:0] opc, input statetype st,
                       input logic [17:0] ctl, input string nm);
        vec_t v;
        v.mr = mr; v.opc = opc; v.st = st; v.ctl = ctl; v.nm = nm;
        vecs.push_back(v);
    endtask

    // scoreboard check: state and packed control word
    task automatic check(input statetype st, input logic [17:0] ctl, input string nm);
        logic [17:0] act;
        act = {irwrite, pcwrite, branch, bltbranch, iord, memwrite, memtoreg,
               regdst, regwrite, alusrca, alusrcb, pcsrc, aluop, illegal_op};
        total++;
        if (dbg_state !== st) begin
            bad++;
            $display("FAIL %s state: got %0d expected %0d", nm, dbg_state, st);
        end
        total++;
        if (act !== ctl) begin
            bad++;
            $display("FAIL %s ctl: got %b expected %b", nm, act, ctl);
        end
        // invariants
        total++;
        if ((branch & bltbranch) || (regwrite & memwrite)) begin
            bad++;
            $display("FAIL %s exclusive strobes: br=%b blt=%b rw=%b mw=%b",
                     nm, branch, bltbranch, regwrite, memwrite);
        end
    endtask

    // driver: one cycle, inputs applied after falling edge, checked 1 ns later
    task automatic step(input logic mr, input logic [5:0] opc, input statetype st,
                        input logic [17:0] ctl, input string nm);
        @(negedge clk);
        mem_ready = mr;
        op        = opc;
        #1;
        check(st, ctl, nm);
    endtask

    initial begin
        reset_n   = 1'b0;
        mem_ready = 1'b0;
        op        = OP_RTYPE;
        repeat (2) @(negedge clk);
        #1;
        check(S_FETCH, c_fwait, "reset");
        @(negedge clk);
        reset_n = 1'b1;

        // lw with stalls on fetch and on read
        add(0, OP_LW, S_FETCH,   c_fwait,  "lw_fstall");
        add(1, OP_LW, S_FETCH,   c_frdy,   "lw_fetch");
        add(1, OP_LW, S_DECODE,  c_dec,    "lw_decode");
        add(1, OP_LW, S_MEMADR,  c_memadr, "lw_memadr");
        add(0, OP_LW, S_MEMRD,   c_memrd,  "lw_rstall");
        add(1, OP_LW, S_MEMRD,   c_memrd,  "lw_memrd");
        add(1, OP_LW, S_MEMWB,   c_memwb,  "lw_memwb");
        // lw, no stall: 5 cycles
        add(1, OP_LW, S_FETCH,   c_frdy,   "lw2_fetch");
        add(1, OP_LW, S_DECODE,  c_dec,    "lw2_decode");
        add(1, OP_LW, S_MEMADR,  c_memadr, "lw2_memadr");
        add(1, OP_LW, S_MEMRD,   c_memrd,  "lw2_memrd");
        add(1, OP_LW, S_MEMWB,   c_memwb,  "lw2_memwb");
        // R-type
        add(1, OP_RTYPE, S_FETCH,   c_frdy,  "r_fetch");
        add(1, OP_RTYPE, S_DECODE,  c_dec,   "r_decode");
        add(1, OP_RTYPE, S_EXECUTE, c_exec,  "r_exec");
        add(1, OP_RTYPE, S_ALUWB,   c_aluwb, "r_aluwb");
        // blt
        add(1, OP_BLT, S_FETCH,  c_frdy, "blt_fetch");
        add(1, OP_BLT, S_DECODE, c_dec,  "blt_decode");
        add(1, OP_BLT, S_BLT,    c_blt,  "blt_ex");
        // beq
        add(1, OP_BEQ, S_FETCH,  c_frdy, "beq_fetch");
        add(1, OP_BEQ, S_DECODE, c_dec,  "beq_decode");
        add(1, OP_BEQ, S_BEQ,    c_beq,  "beq_ex");
        // li
        add(1, OP_LI, S_FETCH,  c_frdy,   "li_fetch");
        add(1, OP_LI, S_DECODE, c_dec,    "li_decode");
        add(1, OP_LI, S_LIEX,   c_liex,   "li_ex");
        add(1, OP_LI, S_ADDIWB, c_addiwb, "li_wb");
        // addi
        add(1, OP_ADDI, S_FETCH,  c_frdy,   "addi_fetch");
        add(1, OP_ADDI, S_DECODE, c_dec,    "addi_decode");
        add(1, OP_ADDI, S_ADDIEX, c_addiex, "addi_ex");
        add(1, OP_ADDI, S_ADDIWB, c_addiwb, "addi_wb");
        // j
        add(1, OP_J, S_FETCH,  c_frdy, "j_fetch");
        add(1, OP_J, S_DECODE, c_dec,  "j_decode");
        add(1, OP_J, S_JUMP,   c_jump, "j_jump");
        add(0, OP_J, S_FETCH,  c_fwait, "j_done");

        foreach (vecs[i]) step(vecs[i].mr, vecs[i].opc, vecs[i].st, vecs[i].ctl, vecs[i].nm);

        // sw with three stall cycles in MEMWR
        step(1, OP_SW, S_FETCH,  c_frdy,   "sw_fetch");
        step(1, OP_SW, S_DECODE, c_dec,    "sw_decode");
        step(1, OP_SW, S_MEMADR, c_memadr, "sw_memadr");
        for (int k = 0; k < 3; k++) step(0, OP_SW, S_MEMWR, c_memwr, "sw_stall");
        step(1, OP_SW, S_MEMWR, c_memwr, "sw_memwr");
        step(0, OP_SW, S_FETCH, c_fwait, "sw_done");

        // illegal opcode: 2 cycles, pulse only in DECODE
        step(1, 6'b111111, S_FETCH,  c_frdy,   "ill_fetch");
        step(1, 6'b111111, S_DECODE, c_decill, "ill_decode");
        step(0, 6'b111111, S_FETCH,  c_fwait,  "ill_after");

        // reset asserted in the middle of MEMWR
        step(1, OP_SW, S_FETCH,  c_frdy,   "rst_fetch");
        step(1, OP_SW, S_DECODE, c_dec,    "rst_decode");
        step(1, OP_SW, S_MEMADR, c_memadr, "rst_memadr");
        step(1, OP_SW, S_MEMWR,  c_memwr,  "rst_memwr");
        #2;
        reset_n = 1'b0;
        #1;
        check(S_FETCH, c_fwait, "rst_abort");
        @(negedge clk);
        #1;
        check(S_FETCH, c_fwait, "rst_hold");
        reset_n   = 1'b1;
        mem_ready = 1'b0;
        #1;
        check(S_FETCH, c_fwait, "rst_release");
        step(0, OP_SW, S_FETCH, c_fwait, "rst_idle");
        step(1, OP_SW, S_FETCH, c_frdy,  "rst_refetch");
        step(1, OP_SW, S_DECODE, c_dec,  "rst_redecode");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
